dw_sel_pipe: RTL

Parametrised, registered successor to the MicroUAZ8 data-write source selector. Picks one of `NSRC` source words of `WIDTH` bits by index and presents it through a one-cycle pipeline register with a valid/ready handshake and a 2-deep skid buffer, so the register-file write port can stall without losing data. Out-of-range selects produce zero data and set a sticky error flag. It sits between the decode/operand stage (sources: R0, data bus, immediate, instruction-address bus, Ry, …) and the register-file write port.

---
 rtl/dw_sel_pkg.sv | 22 ++
 rtl/dw_src_mux.sv | 33 +++
 rtl/dw_sel_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/dw_sel_pkg.sv
// Shared types and constants for the data-write source selector pipeline.
package dw_sel_pkg;

  // Occupancy of the output/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Default geometry matching the MicroUAZ8 datapath.
  localparam int DW_WIDTH_DEF = 8;
  localparam int DW_NSRC_DEF  = 5;

  // MicroUAZ8 source map.
  localparam int SRC_R0         = 0;
  localparam int SRC_DATO_BUS   = 1;
  localparam int SRC_NUM        = 2;
  localparam int SRC_ADDR_INSTR = 3;
  localparam int SRC_RY         = 4;

endpackage

// File: rtl/dw_src_mux.sv
// Combinational NSRC:1 word selector; an index with no matching source yields
// zero data and raises oor_o.
module dw_src_mux #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 5,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic [SELW-1:0]       sel_i,
  input  logic [NSRC*WIDTH-1:0] src_i,
  output logic [WIDTH-1:0]      word_o,
  output logic                  oor_o
);

  logic [NSRC-1:0]  hit;
  logic [WIDTH-1:0] masked [NSRC];

  // One-hot decode of the index and per-source gating.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign hit[gi]    = (sel_i == SELW'(gi));
    assign masked[gi] = hit[gi] ? src_i[gi*WIDTH +: WIDTH] : '0;
  end

  // OR-combine the gated words; at most one is non-zero.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < NSRC; k++) begin
      word_o = word_o | masked[k];
    end
  end

  assign oor_o = ~|hit;

endmodule

// File: rtl/dw_sel_pipe.sv
// Registered source selector with valid/ready handshake and a skid register
// so the register-file write port may stall without losing words.
module dw_sel_pipe
  import dw_sel_pkg::*;
#(
  parameter int WIDTH = DW_WIDTH_DEF,
  parameter int NSRC  = DW_NSRC_DEF,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [SELW-1:0]       i_Sel,
  input  logic [NSRC*WIDTH-1:0] i_Src,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  output logic [WIDTH-1:0]      o_DW,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic                  o_Err,
  input  logic                  i_Clr_Err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dw_q, dw_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] word;
  logic             oor;
  logic             accept;
  logic             take;

  dw_src_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_mux (
    .sel_i  (i_Sel),
    .src_i  (i_Src),
    .word_o (word),
    .oor_o  (oor)
  );

  // Handshake flags decode only the state register, so i_Ready never reaches o_Ready.
  assign o_Ready = (state_q != ST_SKID);
  assign o_Valid = (state_q != ST_EMPTY);
  assign o_DW    = dw_q;
  assign o_Err   = err_q;
  assign accept  = i_Valid & o_Ready;
  assign take    = o_Valid & i_Ready;

  // Next-state, data movement and sticky error (set beats clear).
  always_comb begin
    state_d = state_q;
    dw_d    = dw_q;
    skid_d  = skid_q;
    err_d   = (accept & oor) | (err_q & ~i_Clr_Err);
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          dw_d    = word;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && take) begin
          dw_d = word;
        end else if (accept) begin
          skid_d  = word;
          state_d = ST_SKID;
        end else if (take) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (take) begin
          dw_d    = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and data registers; reset discards any held words.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_EMPTY;
      dw_q    <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dw_q    <= dw_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

endmodule
